// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared memory port.
// master = requesters plus memory, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data port wins ties unless fetch has already lost MAX_WAIT cycles in a row.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int            CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e          owner_q, owner_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            if_gnt_s, d_gnt_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_addr_s;
    logic [DW-1:0]   mem_wdata_s;
    logic [DW/8-1:0] mem_be_s;

    // Grant decision, memory mux and next owner / starvation count.
    always_comb begin
        if_gnt_s    = 1'b0;
        d_gnt_s     = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        mem_be_s    = '0;
        owner_d     = OWN_NONE;
        wait_d      = '0;
        if (!reset) begin
            owner_d = OWN_NONE;
            wait_d  = '0;
        end else begin
            if (bus.d_req && bus.if_req) begin
                if (wait_q == WAIT_LIMIT) begin
                    if_gnt_s = 1'b1;
                end else begin
                    d_gnt_s = 1'b1;
                end
            end else if (bus.d_req) begin
                d_gnt_s = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_s = 1'b1;
            end else begin
                if_gnt_s = 1'b0;
                d_gnt_s  = 1'b0;
            end

            if (d_gnt_s) begin
                mem_we_s    = bus.d_we;
                mem_addr_s  = bus.d_addr;
                mem_wdata_s = bus.d_wdata;
                mem_be_s    = bus.d_be;
                owner_d     = OWN_D;
            end else if (if_gnt_s) begin
                mem_addr_s  = bus.if_addr;
                owner_d     = OWN_IF;
            end else begin
                owner_d     = OWN_NONE;
            end

            // Saturating count of consecutive cycles fetch asked and lost.
            if (bus.if_req && !if_gnt_s) begin
                wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + CW'(1);
            end else begin
                wait_d = '0;
            end
        end
    end

    // Owner and starvation counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q <= OWN_NONE;
            wait_q  <= '0;
        end else begin
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.mem_req   = if_gnt_s | d_gnt_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.mem_be    = mem_be_s;

    // An access granted just before a reset edge is dropped: owner clears, rvalid stays low.
    assign bus.if_rvalid = reset && (owner_q == OWN_IF);
    assign bus.d_rvalid  = reset && (owner_q == OWN_D);
    assign bus.if_rdata  = reset ? bus.mem_rdata : '0;
    assign bus.d_rdata   = reset ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // Memory returns the address of the previous access as its read data.
    always @(posedge clk) begin
        if (bus.mem_req) bus.mem_rdata <= bus.mem_addr;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lost;
    int          resp_who;
    logic [31:0] resp_addr;
    logic        resp_we;
    logic        e_if, e_d, g_if, g_d, s_if;
    logic        if_pend, d_pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        #1;
        if (!rst) begin
            e_if = 1'b0;
            e_d  = 1'b0;
        end else if (bus.if_req && bus.d_req) begin
            e_if = (lost >= MAX_WAIT);
            e_d  = !e_if;
        end else begin
            e_if = bus.if_req;
            e_d  = bus.d_req;
        end
        s_if = bus.if_gnt;
        chk("if_gnt", bus.if_gnt, e_if);
        chk("d_gnt", bus.d_gnt, e_d);
        chk("mem_req", bus.mem_req, e_if | e_d);
        chk("mem_we", bus.mem_we, e_d & bus.d_we);
        if (e_d) begin
            chk("mem_addr_d", bus.mem_addr, bus.d_addr);
            chk("mem_wdata_d", bus.mem_wdata, bus.d_wdata);
            chk("mem_be_d", bus.mem_be, bus.d_be);
        end else if (e_if || !rst) begin
            chk("mem_addr_if", bus.mem_addr, e_if ? bus.if_addr : 32'h0);
            chk("mem_wdata_0", bus.mem_wdata, 32'h0);
            chk("mem_be_0", bus.mem_be, 4'h0);
        end
        chk("if_rvalid", bus.if_rvalid, rst && (resp_who == 1));
        chk("d_rvalid", bus.d_rvalid, rst && (resp_who == 2));
        if (!rst) begin
            chk("if_rdata_rst", bus.if_rdata, 32'h0);
            chk("d_rdata_rst", bus.d_rdata, 32'h0);
        end else if (resp_who == 1) begin
            chk("if_rdata", bus.if_rdata, resp_addr);
        end else if (resp_who == 2 && !resp_we) begin
            chk("d_rdata", bus.d_rdata, resp_addr);
        end
        if (!rst) begin
            lost     = 0;
            resp_who = 0;
        end else begin
            resp_who  = e_d ? 2 : (e_if ? 1 : 0);
            resp_addr = e_d ? bus.d_addr : bus.if_addr;
            resp_we   = e_d && bus.d_we;
            if (bus.if_req && !e_if) lost = (lost < MAX_WAIT) ? lost + 1 : lost;
            else lost = 0;
        end
        g_if = e_if;
        g_d  = e_d;
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_be    = 4'h0;
        lost        = 0;
        resp_who    = 0;
        resp_addr   = 32'h0;
        resp_we     = 1'b0;
        if_pend     = 1'b0;
        d_pend      = 1'b0;
        @(negedge clk);

        // Reset held with both requesting.
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        bus.if_addr = 32'h40;
        bus.d_addr  = 32'h80;
        repeat (3) step();

        // Fetch only, two consecutive addresses.
        rst = 1'b1;
        bus.d_req = 1'b0;
        bus.if_addr = 32'h0;
        step();
        bus.if_addr = 32'h4;
        step();
        bus.if_req = 1'b0;
        step();

        // Both held: four data grants then one forced fetch grant.
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_addr  = 32'h300;
        bus.d_we    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("tput_if_gnt", s_if, (i % 5) == 4);
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();

        // Store.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_be    = 4'hF;
        step();
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        step();

        // Alternating fetch and load grants.
        for (int i = 0; i < 8; i++) begin
            bus.if_req  = (i % 2) == 1;
            bus.d_req   = (i % 2) == 0;
            bus.if_addr = 32'h1000 + 32'(i * 4);
            bus.d_addr  = 32'h2000 + 32'(i * 4);
            step();
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();

        // Reset right after a data grant discards its response.
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h3000;
        step();
        bus.d_req = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        step();
        bus.if_req = 1'b0;
        step();

        // Random traffic with requests held until granted and occasional resets.
        for (int c = 0; c < 400; c++) begin
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend     = 1'b1;
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend      = 1'b1;
                bus.d_addr  = $urandom & 32'hFFFF_FFFC;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_wdata = $urandom;
                bus.d_be    = 4'($urandom_range(0, 15));
            end
            bus.if_req = if_pend;
            bus.d_req  = d_pend;
            rst = ($urandom_range(0, 49) != 0);
            step();
            if (g_if) if_pend = 1'b0;
            if (g_d)  d_pend  = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
